decode_q: RTL and testbench

Instruction decode stage directly downstream of the quesadilla fetch datapath; consumes the 32-bit instQ word each cycle. Cracks the MIPS-style instruction into register indices, extended immediate and control flags. Holds the decoded results in a 2-entry skid buffer so the execute stage can stall without losing fetched words. Presents a valid/ready interface on both sides.

---
 rtl/decode_q_pkg.sv | 47 ++++
 rtl/decode_q_skid.sv | 90 +++++++++
 rtl/decode_q.sv | 135 +++++++++++++
 tb/tb_decode_q.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_q_pkg.sv
// Shared constants and the decoded-instruction bundle for the decode_q stage.
package decode_q_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 2;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL = 6'h00;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SLT = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;

  typedef struct packed {
    logic [5:0]      opcode;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      wr_reg;
    logic [XLEN-1:0] imm_ext;
    logic [3:0]      alu_op;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            jump;
    logic            illegal;
  } decoded_t;

  localparam int unsigned BUNDLE_W = $bits(decoded_t);

endpackage

// File: rtl/decode_q_skid.sv
// Two-entry valid/ready skid buffer; entry 0 is always the head.
module decode_q_skid #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

  state_t       state, state_nxt;
  logic [W-1:0] ent0, ent1;
  logic         push, pop;
  logic         ld0_in, ld0_shift, ld1_in;

  // Flush drops both the incoming word and any pending pop.
  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  // Occupancy transitions and entry load selects.
  always_comb begin
    state_nxt = state;
    ld0_in    = 1'b0;
    ld0_shift = 1'b0;
    ld1_in    = 1'b0;
    if (flush) begin
      state_nxt = S_EMPTY;
    end else begin
      case (state)
        S_EMPTY: begin
          if (push) begin
            state_nxt = S_ONE;
            ld0_in    = 1'b1;
          end
        end
        S_ONE: begin
          if (push && pop) begin
            ld0_in = 1'b1;
          end else if (push) begin
            state_nxt = S_FULL;
            ld1_in    = 1'b1;
          end else if (pop) begin
            state_nxt = S_EMPTY;
          end
        end
        S_FULL: begin
          if (pop) begin
            state_nxt = S_ONE;
            ld0_shift = 1'b1;
          end
        end
        default: state_nxt = S_EMPTY;
      endcase
    end
  end

  // State, registered handshake flags and entry storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      ent0      <= '0;
      ent1      <= '0;
    end else begin
      state     <= state_nxt;
      out_valid <= (state_nxt != S_EMPTY);
      in_ready  <= (state_nxt != S_FULL);
      if (ld0_in) begin
        ent0 <= in_data;
      end else if (ld0_shift) begin
        ent0 <= ent1;
      end
      if (ld1_in) begin
        ent1 <= in_data;
      end
    end
  end

  // Stale head contents are masked while the buffer is empty.
  assign out_data = out_valid ? ent0 : '0;

endmodule

// File: rtl/decode_q.sv
// Instruction decode stage: cracks instQ and buffers the result in a skid buffer.
module decode_q
  import decode_q_pkg::*;
(
  input  logic             clk_q,
  input  logic             rst_q,
  input  logic [XLEN-1:0]  instQ,
  input  logic             inst_valid,
  output logic             inst_ready,
  input  logic             flush,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [5:0]       opcode,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       wr_reg,
  output logic [XLEN-1:0]  imm_ext,
  output logic [3:0]       alu_op,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             branch,
  output logic             jump,
  output logic             illegal
);

  // Combinational crack of one instruction word into the decoded bundle.
  function automatic decoded_t decode(input logic [XLEN-1:0] w);
    decoded_t   d;
    logic [5:0] op;
    logic [5:0] fn;
    d        = '0;
    op       = w[31:26];
    fn       = w[5:0];
    d.opcode = op;
    d.rs     = w[25:21];
    d.rt     = w[20:16];
    d.alu_op = ALU_ADD;
    case (op)
      OP_RTYPE: begin
        d.wr_reg    = w[15:11];
        d.reg_write = 1'b1;
        case (fn)
          F_ADD: d.alu_op = ALU_ADD;
          F_SUB: d.alu_op = ALU_SUB;
          F_AND: d.alu_op = ALU_AND;
          F_OR:  d.alu_op = ALU_OR;
          F_SLT: d.alu_op = ALU_SLT;
          F_SLL: begin
            d.alu_op    = ALU_SLL;
            d.reg_write = (w != '0);  // all-zero word is a NOP
          end
          default: begin
            d.wr_reg    = 5'd0;
            d.reg_write = 1'b0;
            d.illegal   = 1'b1;
          end
        endcase
      end
      OP_ADDI: begin
        d.imm_ext   = {{16{w[15]}}, w[15:0]};
        d.wr_reg    = w[20:16];
        d.reg_write = 1'b1;
      end
      OP_ANDI: begin
        d.imm_ext   = {16'd0, w[15:0]};
        d.alu_op    = ALU_AND;
        d.wr_reg    = w[20:16];
        d.reg_write = 1'b1;
      end
      OP_ORI: begin
        d.imm_ext   = {16'd0, w[15:0]};
        d.alu_op    = ALU_OR;
        d.wr_reg    = w[20:16];
        d.reg_write = 1'b1;
      end
      OP_LW: begin
        d.imm_ext   = {{16{w[15]}}, w[15:0]};
        d.wr_reg    = w[20:16];
        d.reg_write = 1'b1;
        d.mem_read  = 1'b1;
      end
      OP_SW: begin
        d.imm_ext   = {{16{w[15]}}, w[15:0]};
        d.mem_write = 1'b1;
      end
      OP_BEQ: begin
        d.imm_ext = {{16{w[15]}}, w[15:0]};
        d.alu_op  = ALU_SUB;
        d.branch  = 1'b1;
      end
      OP_J: begin
        d.imm_ext = {6'd0, w[25:0]};
        d.jump    = 1'b1;
      end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

  decoded_t             dec_in;
  decoded_t             head;
  logic [BUNDLE_W-1:0]  head_bits;

  assign dec_in = decode(instQ);

  decode_q_skid #(
    .W (BUNDLE_W)
  ) u_skid (
    .clk       (clk_q),
    .rst       (rst_q),
    .in_valid  (inst_valid),
    .in_ready  (inst_ready),
    .in_data   (dec_in),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (head_bits)
  );

  assign head      = decoded_t'(head_bits);
  assign opcode    = head.opcode;
  assign rs        = head.rs;
  assign rt        = head.rt;
  assign wr_reg    = head.wr_reg;
  assign imm_ext   = head.imm_ext;
  assign alu_op    = head.alu_op;
  assign reg_write = head.reg_write;
  assign mem_read  = head.mem_read;
  assign mem_write = head.mem_write;
  assign branch    = head.branch;
  assign jump      = head.jump;
  assign illegal   = head.illegal;

endmodule

// File: tb/tb_decode_q.sv
// Randomized and directed bench for decode_q against a queue-based reference.
module tb_decode_q;

  logic        clk_q = 1'b0;
  logic        rst_q = 1'b1;
  logic [31:0] instQ = '0;
  logic        inst_valid = 1'b0;
  logic        inst_ready;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, wr_reg;
  logic [31:0] imm_ext;
  logic [3:0]  alu_op;
  logic        reg_write, mem_read, mem_write, branch, jump, illegal;

  int n_checks = 0;
  int n_errors = 0;
  logic [62:0] q[$];
  logic [62:0] dut_bundle;

  decode_q dut (
    .clk_q      (clk_q),
    .rst_q      (rst_q),
    .instQ      (instQ),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .flush      (flush),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .opcode     (opcode),
    .rs         (rs),
    .rt         (rt),
    .wr_reg     (wr_reg),
    .imm_ext    (imm_ext),
    .alu_op     (alu_op),
    .reg_write  (reg_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .branch     (branch),
    .jump       (jump),
    .illegal    (illegal)
  );

  always #5 clk_q = ~clk_q;

  assign dut_bundle = {opcode, rs, rt, wr_reg, imm_ext, alu_op,
                       reg_write, mem_read, mem_write, branch, jump, illegal};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference decode from the instruction table, packed like dut_bundle.
  function automatic logic [62:0] ref_decode(input logic [31:0] w);
    int unsigned op = w[31:26];
    int unsigned fn = w[5:0];
    int unsigned lo = w[15:0];
    logic [31:0] imm = 0;
    logic [4:0]  wr = 0;
    int unsigned alu = 0;
    bit rw = 0, mr = 0, mw = 0, br = 0, jp = 0, ill = 0;
    if (op == 0) begin
      if      (fn == 'h20) alu = 0;
      else if (fn == 'h22) alu = 1;
      else if (fn == 'h24) alu = 2;
      else if (fn == 'h25) alu = 3;
      else if (fn == 'h2A) alu = 4;
      else if (fn == 'h00) alu = 5;
      else ill = 1;
      if (!ill) begin
        wr = w[15:11];
        rw = (w != 0);
      end
    end else if (op == 'h08 || op == 'h23) begin
      imm = (lo >= 'h8000) ? 32'(lo) - 32'h10000 : 32'(lo);
      wr = w[20:16];
      rw = 1;
      mr = (op == 'h23);
    end else if (op == 'h0C || op == 'h0D) begin
      imm = 32'(lo);
      alu = (op == 'h0C) ? 2 : 3;
      wr = w[20:16];
      rw = 1;
    end else if (op == 'h2B) begin
      imm = (lo >= 'h8000) ? 32'(lo) - 32'h10000 : 32'(lo);
      mw = 1;
    end else if (op == 'h04) begin
      imm = (lo >= 'h8000) ? 32'(lo) - 32'h10000 : 32'(lo);
      alu = 1;
      br = 1;
    end else if (op == 'h02) begin
      imm = 32'(w[25:0]);
      jp = 1;
    end else begin
      ill = 1;
    end
    return {w[31:26], w[25:21], w[20:16], wr, imm, 4'(alu), rw, mr, mw, br, jp, ill};
  endfunction

  task automatic compare_all(input string tag);
    logic [62:0] exp_b;
    exp_b = (q.size() > 0) ? q[0] : 63'd0;
    check($sformatf("%s.out_valid", tag), 64'(out_valid), 64'(q.size() > 0));
    check($sformatf("%s.inst_ready", tag), 64'(inst_ready), 64'(q.size() < 2));
    check($sformatf("%s.bundle", tag), 64'(dut_bundle), 64'(exp_b));
  endtask

  // One clock: drive on negedge, update reference at posedge, compare after it.
  task automatic step(input logic [31:0] w, input logic v, input logic r, input logic f,
                      input string tag);
    bit acc, pp;
    @(negedge clk_q);
    instQ = w;
    inst_valid = v;
    out_ready = r;
    flush = f;
    @(posedge clk_q);
    acc = v && (q.size() < 2);
    pp  = r && (q.size() > 0);
    if (f) begin
      q.delete();
    end else begin
      if (pp) void'(q.pop_front());
      if (acc) q.push_back(ref_decode(w));
    end
    #1;
    compare_all(tag);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    int unsigned k;
    w = $urandom;
    k = $urandom_range(0, 11);
    case (k)
      0, 1: begin
        w[31:26] = 6'h00;
        case ($urandom_range(0, 6))
          0: w[5:0] = 6'h20;
          1: w[5:0] = 6'h22;
          2: w[5:0] = 6'h24;
          3: w[5:0] = 6'h25;
          4: w[5:0] = 6'h2A;
          5: w[5:0] = 6'h00;
          default: w[5:0] = 6'h21;
        endcase
      end
      2: w[31:26] = 6'h08;
      3: w[31:26] = 6'h0C;
      4: w[31:26] = 6'h0D;
      5: w[31:26] = 6'h23;
      6: w[31:26] = 6'h2B;
      7: w[31:26] = 6'h04;
      8: w[31:26] = 6'h02;
      9: w = 32'd0;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] wa, wb, wc;

    // Reset state while held in reset.
    #12;
    compare_all("reset");
    @(negedge clk_q);
    rst_q = 1'b0;

    // Single ADD.
    step(32'h012A4020, 1, 1, 0, "add");
    check("add.rs", 64'(rs), 64'd9);
    check("add.rt", 64'(rt), 64'd10);
    check("add.wr_reg", 64'(wr_reg), 64'd8);
    check("add.alu_op", 64'(alu_op), 64'd0);
    check("add.reg_write", 64'(reg_write), 64'd1);

    // Sign and zero extension.
    step(32'h8D28FFFC, 1, 1, 0, "lw");
    check("lw.imm_ext", 64'(imm_ext), 64'hFFFFFFFC);
    check("lw.mem_read", 64'(mem_read), 64'd1);
    check("lw.wr_reg", 64'(wr_reg), 64'd8);
    step(32'h3528FFFC, 1, 1, 0, "ori");
    check("ori.imm_ext", 64'(imm_ext), 64'h0000FFFC);

    // Illegal opcode and NOP.
    step(32'hFC000000, 1, 1, 0, "ill");
    check("ill.illegal", 64'(illegal), 64'd1);
    check("ill.flags", 64'({reg_write, mem_read, mem_write, branch}), 64'd0);
    step(32'h00000000, 1, 1, 0, "nop");
    check("nop.illegal", 64'(illegal), 64'd0);
    check("nop.reg_write", 64'(reg_write), 64'd0);
    check("nop.out_valid", 64'(out_valid), 64'd1);
    step(32'h0, 0, 1, 0, "drain0");

    // Backpressure with three words; third is held upstream.
    wa = 32'h01095020;
    wb = 32'h21280005;
    wc = 32'hAD2A0010;
    step(wa, 1, 0, 0, "bp1");
    step(wb, 1, 0, 0, "bp2");
    check("bp.inst_ready", 64'(inst_ready), 64'd0);
    check("bp.head", 64'(dut_bundle), 64'(ref_decode(wa)));
    step(wc, 1, 0, 0, "bp3");
    step(wc, 1, 1, 0, "bp4");
    check("bp.head_b", 64'(dut_bundle), 64'(ref_decode(wb)));
    step(wc, 1, 1, 0, "bp5");
    check("bp.head_c", 64'(dut_bundle), 64'(ref_decode(wc)));
    step(32'h0, 0, 1, 0, "bp6");
    check("bp.empty", 64'(out_valid), 64'd0);

    // Flush with a simultaneous push at count=2.
    step(wa, 1, 0, 0, "fl1");
    step(wb, 1, 0, 0, "fl2");
    step(wc, 1, 1, 1, "fl3");
    check("fl.out_valid", 64'(out_valid), 64'd0);
    check("fl.inst_ready", 64'(inst_ready), 64'd1);
    step(32'h0, 0, 1, 0, "fl4");
    check("fl.dropped", 64'(out_valid), 64'd0);

    // Asynchronous reset mid-cycle with entries buffered.
    step(wa, 1, 0, 0, "rs1");
    step(wb, 1, 0, 0, "rs2");
    @(posedge clk_q);
    #3;
    rst_q = 1'b1;
    #1;
    q.delete();
    check("arst.out_valid", 64'(out_valid), 64'd0);
    check("arst.inst_ready", 64'(inst_ready), 64'd1);
    check("arst.bundle", 64'(dut_bundle), 64'd0);
    @(negedge clk_q);
    inst_valid = 1'b0;
    rst_q = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      step(rand_inst(), 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 6),
           1'($urandom_range(0, 19) == 0), $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
